// File: rtl/reg_file_mport_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_mport_if
// Brief    : Read/write/clear bus for the multi-port register file.
// Revision : 1.0
// ============================================================================
interface reg_file_mport_if #(
    parameter int S_AD   = 5,
    parameter int S_DATA = 32,
    parameter int N_RD   = 2
);
    logic [N_RD*S_AD-1:0]   ARead;
    logic [N_RD*S_DATA-1:0] DRead;
    logic [S_AD-1:0]        AWR;
    logic [S_DATA-1:0]      DataIn;
    logic                   WE;
    logic                   ClrReq;
    logic                   Busy;
    logic                   WrDrop;

    modport master (
        output ARead, AWR, DataIn, WE, ClrReq,
        input  DRead, Busy, WrDrop
    );

    modport slave (
        input  ARead, AWR, DataIn, WE, ClrReq,
        output DRead, Busy, WrDrop
    );
endinterface
`default_nettype wire

// File: rtl/reg_file_mport.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_mport
// Brief    : 2**S_AD x S_DATA register file, one sync write port, N_RD async
//            read ports, hardware clear sweep. Optional write-to-read
//            forwarding enabled by macro REGFILE_BYPASS_EN.
// Revision : 1.0
// ============================================================================
module reg_file_mport #(
    parameter int S_AD     = 5,
    parameter int S_DATA   = 32,
    parameter int N_RD     = 2,
    parameter int ZERO_REG = 1
) (
    input  wire logic       Clk,
    input  wire logic       RstN,
    reg_file_mport_if.slave bus
);

    localparam int DEPTH = 2 ** S_AD;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t                r_state;
    logic [S_AD-1:0]       r_clr_idx;
    logic                  r_busy;
    logic                  r_wr_drop;
    logic [S_DATA-1:0]     r_mem [DEPTH];

    logic                  w_wr_zero;
    logic                  w_mem_we;
    logic [S_AD-1:0]       w_mem_addr;
    logic [S_DATA-1:0]     w_mem_data;
    logic [N_RD*S_DATA-1:0] w_dread;

    assign w_wr_zero = (ZERO_REG != 0) && (bus.AWR == '0);

    always_ff @(posedge Clk) begin
        if (!RstN) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
            r_busy    <= 1'b1;
            r_wr_drop <= 1'b0;
        end else begin
            r_wr_drop <= 1'b0;
            case (r_state)
                ST_CLEAR: begin
                    r_wr_drop <= bus.WE;
                    r_clr_idx <= r_clr_idx + 1'b1;
                    if (&r_clr_idx) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    if (bus.ClrReq) begin
                        r_state   <= ST_CLEAR;
                        r_clr_idx <= '0;
                        r_busy    <= 1'b1;
                    end
                end
            endcase
        end
    end

    // A write coinciding with ClrReq is dropped silently: the sweep zeroes it anyway.
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = bus.AWR;
        w_mem_data = bus.DataIn;
        if (RstN) begin
            if (r_state == ST_CLEAR) begin
                w_mem_we   = 1'b1;
                w_mem_addr = r_clr_idx;
                w_mem_data = '0;
            end else if (bus.WE && !bus.ClrReq && !w_wr_zero) begin
                w_mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        logic [S_AD-1:0]   w_ra;
        logic [S_DATA-1:0] w_rd;

        assign w_ra = bus.ARead[k*S_AD +: S_AD];

        always_comb begin
            w_rd = r_mem[w_ra];
            if ((r_state == ST_CLEAR) || ((ZERO_REG != 0) && (w_ra == '0))) begin
                w_rd = '0;
            end
`ifdef REGFILE_BYPASS_EN
            else if (bus.WE && !w_wr_zero && (bus.AWR == w_ra)) begin
                w_rd = bus.DataIn;
            end
`else
`endif
        end

        assign w_dread[k*S_DATA +: S_DATA] = w_rd;
    end

    assign bus.DRead  = w_dread;
    assign bus.Busy   = r_busy;
    assign bus.WrDrop = r_wr_drop;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mport.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_mport
// Brief    : Scoreboard bench for reg_file_mport (ZERO_REG=1 and ZERO_REG=0).
// Revision : 1.0
// ============================================================================
module tb_reg_file_mport;

    localparam int K_RD = 0;
    localparam int K_BUSY = 1;
    localparam int K_DROP = 2;

    logic Clk;
    logic RstN;

    reg_file_mport_if #(.S_AD(5), .S_DATA(32), .N_RD(2)) bus0 ();
    reg_file_mport_if #(.S_AD(5), .S_DATA(32), .N_RD(2)) bus1 ();

    assign bus1.ARead  = bus0.ARead;
    assign bus1.AWR    = bus0.AWR;
    assign bus1.DataIn = bus0.DataIn;
    assign bus1.WE     = bus0.WE;
    assign bus1.ClrReq = bus0.ClrReq;

    reg_file_mport #(.S_AD(5), .S_DATA(32), .N_RD(2), .ZERO_REG(1)) dut0 (
        .Clk (Clk),
        .RstN(RstN),
        .bus (bus0.slave)
    );

    reg_file_mport #(.S_AD(5), .S_DATA(32), .N_RD(2), .ZERO_REG(0)) dut1 (
        .Clk (Clk),
        .RstN(RstN),
        .bus (bus1.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        int          dut;
        int          kind;
        int          lane;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic logic [31:0] get_act(input int dut, input int kind, input int lane);
        logic [63:0] d;
        logic        b;
        logic        w;
        d = (dut == 0) ? bus0.DRead  : bus1.DRead;
        b = (dut == 0) ? bus0.Busy   : bus1.Busy;
        w = (dut == 0) ? bus0.WrDrop : bus1.WrDrop;
        case (kind)
            K_RD:    return d[lane*32 +: 32];
            K_BUSY:  return {31'b0, b};
            default: return {31'b0, w};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every expectation queued for this cycle is compared mid-cycle.
    always @(negedge Clk) begin
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk(e.name, get_act(e.dut, e.kind, e.lane), e.exp);
        end
    end

    task automatic push(input string name, input int dut, input int kind,
                        input int lane, input logic [31:0] exp);
        exp_t e;
        e.name = name; e.dut = dut; e.kind = kind; e.lane = lane; e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1);
        bus0.ARead = {a1, a0};
    endtask

    task automatic drive_wr(input logic we, input logic [4:0] a, input logic [31:0] d);
        bus0.WE = we; bus0.AWR = a; bus0.DataIn = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        RstN = 1'b0;
        drive_wr(1'b0, 5'd0, 32'h0);
        bus0.ClrReq = 1'b0;
        set_ra(5'd0, 5'd0);

        // Reset: one low cycle, then measure sweep length
        tick();
        push("rst_busy", 0, K_BUSY, 0, 32'd1);
        push("rst_wrdrop", 0, K_DROP, 0, 32'd0);
        RstN = 1'b1;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (bus0.Busy === 1'b1) cnt++;
            else break;
        end
        chk("reset_sweep_len", cnt, 32);
        tick();

        for (int a = 0; a < 32; a++) begin
            set_ra(a[4:0], a[4:0]);
            push("clr_rd_l0", 0, K_RD, 0, 32'h0);
            push("clr_rd_l1", 0, K_RD, 1, 32'h0);
            tick();
        end

        // Basic write/read, boundary addresses
        drive_wr(1'b1, 5'd7, 32'hDEADBEEF); tick();
        drive_wr(1'b1, 5'd31, 32'h80000001); tick();
        drive_wr(1'b1, 5'd1, 32'h00000001); tick();
        drive_wr(1'b0, 5'd0, 32'h0);
        set_ra(5'd7, 5'd7);
        push("rd7_l0", 0, K_RD, 0, 32'hDEADBEEF);
        push("rd7_l1", 0, K_RD, 1, 32'hDEADBEEF);
        push("wr_nodrop", 0, K_DROP, 0, 32'd0);
        tick();
        set_ra(5'd31, 5'd1);
        push("rd31_l0", 0, K_RD, 0, 32'h80000001);
        push("rd1_l1", 0, K_RD, 1, 32'h00000001);
        tick();

        // Register 0 behaviour
        drive_wr(1'b1, 5'd0, 32'h12345678); tick();
        drive_wr(1'b0, 5'd0, 32'h0);
        set_ra(5'd0, 5'd0);
        push("z_rd0", 0, K_RD, 0, 32'h0);
        push("z_nodrop", 0, K_DROP, 0, 32'd0);
        push("nz_rd0", 1, K_RD, 0, 32'h12345678);
        push("nz_nodrop", 1, K_DROP, 0, 32'd0);
        tick();

        // Same-cycle read of the write target
        drive_wr(1'b1, 5'd9, 32'h0000CAFE);
        set_ra(5'd7, 5'd9);
`ifdef REGFILE_BYPASS_EN
        push("byp_l1", 0, K_RD, 1, 32'h0000CAFE);
`else
        push("byp_l1", 0, K_RD, 1, 32'h0);
`endif
        push("byp_l0", 0, K_RD, 0, 32'hDEADBEEF);
        tick();
        drive_wr(1'b1, 5'd0, 32'h0000FFFF);
        set_ra(5'd0, 5'd9);
        push("byp_zero", 0, K_RD, 0, 32'h0);
        push("rd9_l1", 0, K_RD, 1, 32'h0000CAFE);
        tick();

        // ClrReq with simultaneous write, then drop test during the sweep
        drive_wr(1'b1, 5'd5, 32'h55555555);
        bus0.ClrReq = 1'b1;
        set_ra(5'd7, 5'd7);
        push("pre_clr_rd7", 0, K_RD, 0, 32'hDEADBEEF);
        tick();
        for (int s = 0; s <= 32; s++) begin
            drive_wr(s == 4, 5'd3, 32'hA5A5A5A5);
            bus0.ClrReq = (s == 9);
            push("sweep_busy", 0, K_BUSY, 0, {31'b0, s < 32});
            if (s == 0) push("clrwe_nodrop", 0, K_DROP, 0, 32'd0);
            if (s == 2) begin
                push("clear_l0", 0, K_RD, 0, 32'h0);
                push("clear_l1", 0, K_RD, 1, 32'h0);
            end
            if (s == 5) push("drop_pulse", 0, K_DROP, 0, 32'd1);
            if (s == 6) push("drop_end", 0, K_DROP, 0, 32'd0);
            tick();
        end
        set_ra(5'd3, 5'd5);
        push("drop_rd3", 0, K_RD, 0, 32'h0);
        push("clrwe_rd5", 0, K_RD, 1, 32'h0);
        tick();
        set_ra(5'd7, 5'd31);
        push("swept_rd7", 0, K_RD, 0, 32'h0);
        push("swept_rd31", 0, K_RD, 1, 32'h0);
        tick();

        // Reset during a sweep restarts it
        bus0.ClrReq = 1'b1;
        tick();
        bus0.ClrReq = 1'b0;
        for (int s = 0; s < 19; s++) begin
            push("mid_busy", 0, K_BUSY, 0, 32'd1);
            tick();
        end
        RstN = 1'b0;
        tick();
        RstN = 1'b1;
        for (int s = 0; s <= 32; s++) begin
            push("rst_mid_busy", 0, K_BUSY, 0, {31'b0, s < 32});
            tick();
        end

        @(negedge Clk);
        #1;
        chk("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_file_mport.md
Name: reg_file_mport

Overview:
- Parametrised, clocked successor to the MIPS32 register file: one synchronous write port, N_RD asynchronous read ports.
- Hardwired-zero register 0 is optional; a hardware clear sequencer zeroes every entry after reset or on request.
- Sits between instruction decode (read addresses from rs/rt fields) and writeback (AWR/DataIn/WE) in the ArqMIPS32 datapath.

Parameters:
- S_AD, 5, address width; depth = 2**S_AD entries.
- S_DATA, 32, data width in bits.
- N_RD, 2, number of read ports; legal range 1..4.
- ZERO_REG, 1: 1 = entry 0 always reads 0 and ignores writes; 0 = entry 0 is an ordinary register.

Ports:
- Clk  in  1  rising-edge clock.
- RstN  in  1  synchronous reset, active-low.
- ARead  in  N_RD*S_AD  read addresses; port k uses bits [k*S_AD +: S_AD].
- DRead  out  N_RD*S_DATA  read data; port k uses bits [k*S_DATA +: S_DATA].
- AWR  in  S_AD  write address.
- DataIn  in  S_DATA  write data.
- WE  in  1  write enable, sampled on Clk rising edge.
- ClrReq  in  1  single-cycle pulse requesting a full clear sweep.
- Busy  out  1  high while the clear sweep runs.
- WrDrop  out  1  one-cycle pulse: a write was discarded because Busy was high.

Behaviour:
- States: CLEAR and IDLE; a clear index ClrIdx is S_AD bits wide.
- Reset (RstN low at a rising edge): state = CLEAR, ClrIdx = 0, Busy = 1, WrDrop = 0. Reset wins over every other input.
- Reset asserted mid-sweep restarts the sweep from index 0.
- CLEAR:
  - Each cycle writes 0 to entry ClrIdx and increments ClrIdx, one entry per cycle.
  - After writing entry 2**S_AD-1, the next state is IDLE and Busy drops on that same edge.
  - The sweep lasts exactly 2**S_AD cycles, with no wrap and no extra cycle.
- CLEAR: all DRead lanes read 0.
- CLEAR: WE=1 at an edge discards the write and pulses WrDrop high for the following cycle.
- CLEAR: ClrReq is ignored.
- IDLE, write: WE=1 at an edge writes DataIn to entry AWR. Read-back latency is 1 cycle, visible after the edge.
  - With ZERO_REG=1, writes to AWR=0 are silently ignored and do not raise WrDrop.
- IDLE, ClrReq=1 at an edge: next state is CLEAR, ClrIdx = 0, Busy = 1.
  - If WE=1 on the same edge, the write is discarded (the sweep would zero it anyway) and WrDrop is not raised.
- Reads are combinational: DRead lane k = entry[ARead lane k].
  - With ZERO_REG=1, ARead = 0 yields 0 regardless of contents.
  - Several lanes may address the same entry; each returns the same value.
- Widths: there is no arithmetic beyond the ClrIdx increment. Entries are exactly S_DATA bits, with no sign extension.
- Busy is a registered output. WrDrop is a registered output, high for one cycle per dropped write.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: in IDLE, when WE=1 and AWR equals ARead lane k, DRead lane k = DataIn combinationally in the same cycle. This is write-to-read forwarding for pipelined writeback.
  - The forward is suppressed when ZERO_REG=1 and AWR=0, and suppressed in CLEAR.
- Undefined: no forwarding. A read returns the old contents until the edge after the write.

Test Plan:
- Reset sweep: RstN low 1 cycle, then high. Busy must stay high for exactly 32 cycles (S_AD=5), then fall. Every address then reads 0x00000000 on all lanes.
- Write/read: IDLE, write 0xDEADBEEF to reg 7. Next cycle, ARead lane0=7 and lane1=7: both lanes read 0xDEADBEEF.
- Zero register: ZERO_REG=1, write 0x12345678 to reg 0. Reg 0 still reads 0 and WrDrop stays 0. With ZERO_REG=0, the same write reads back 0x12345678.
- Dropped write: ClrReq pulse, then WE=1 with AWR=3, DataIn=0xA5A5A5A5 at cycle 5 of the sweep. WrDrop pulses for one cycle. After Busy falls, reg 3 reads 0.
- Reset mid-sweep: RstN low at sweep cycle 20. Busy must stay high for 32 further cycles from the reset edge.
- Bypass (REGFILE_BYPASS_EN): WE=1, AWR=9, DataIn=0x0000CAFE, ARead lane1=9 in the same cycle. DRead lane1 = 0x0000CAFE before the edge. Without the macro it shows the old value.
